t5_hart: RTL and testbench
==========================

Name: t5_hart

Overview:
- Hart scheduler and next-address generator for the four-hart barrel pipeline.
- Holds one word-aligned PC per hart and picks, round-robin, which hart fetches next.
- Issues that hart's fetch address and hart id to the fetch stage.
- Receives the resolved next PC of each retired instruction from execute/writeback.
- Enforces at most one instruction in flight per hart.

Parameters:
- XLEN, 32, datapath width; addresses carried as [XLEN-1:2].
- RST_VEC, 32'h0000_0000, byte reset vector for hart 0; bits [1:0] ignored.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ena  in  1  pipeline advance enable; when low, all state holds.
- wb_stb  in  1  writeback strobe: instruction of wb_hart retired.
- wb_hart  in  2  hart id of the retiring instruction.
- wb_pc  in  XLEN-2  resolved next word address for wb_hart.
- start_stb  in  1  request to start a parked hart.
- start_hart  in  2  hart to start.
- start_pc  in  XLEN-2  start word address.
- halt_stb  in  1  request to park a hart.
- halt_hart  in  2  hart to park.
- fadr  out  XLEN-2  fetch word address of the issued hart.
- fhart  out  2  issued hart id.
- fvld  out  1  fadr/fhart valid this cycle.
- run  out  4  per-hart running mask.

Behaviour:
- Per-hart state: pcf[h] (XLEN-2), run[h], pend[h]. A hart is eligible when run[h] and !pend[h].
- Reset: pcf[0]=RST_VEC[XLEN-1:2], pcf[1..3]=0, run=4'b0001, pend=0, fadr=0, fhart=0, fvld=0, round-robin pointer rr=0.
- All updates occur on posedge clk only when ena=1. With ena=0, every register and output holds, and inputs are ignored (upstream holds them).
- Issue, registered with one cycle latency:
  - Scan rr, rr+1, rr+2, rr+3 mod 4 and select the first eligible hart h.
  - Load fadr<=pcf[h], fhart<=h, fvld<=1, pend[h]<=1, rr<=h+1 mod 4.
  - If no hart is eligible: fvld<=0; fadr/fhart hold; rr unchanged.
- Writeback:
  - On wb_stb: pcf[wb_hart]<=wb_pc and pend[wb_hart]<=0.
  - The hart is eligible in the same cycle's scan: writeback bypasses into the scan, so the issued fadr equals wb_pc.
  - wb_stb for a hart with pend=0 still updates pcf and is otherwise harmless.
- Start:
  - On start_stb with run[start_hart]=0: run<=1, pcf<=start_pc, pend<=0.
  - The hart becomes eligible from the next cycle; it is not bypassed into the same-cycle scan.
  - start_stb on an already-running hart is ignored entirely.
- Halt:
  - On halt_stb: run[halt_hart]<=0, and the hart is excluded from the same-cycle scan.
  - An in-flight instruction still retires; its writeback updates pcf and clears pend, so a later start overwrites pcf.
- Simultaneous events:
  - Writeback and halt on the same hart: pcf is updated, the hart is parked, and it is not issued.
  - Start and halt on the same hart: halt wins and run stays 0.
  - Writeback and start on the same parked hart: start_pc wins.
- Wrap-around: rr is 2 bits and wraps naturally. The PC is not modified here; no increment logic is present, since sequential next-PC comes from execute via wb_pc.
- Fairness: with all four harts eligible every cycle, issue order is 0,1,2,3,0, and so on.

Decomposition:
- Shared package t5_pkg holds:
  - NHART=4 and HART_W=2.
  - The hart-id typedef.
  - The word-address typedef [XLEN-1:2].
- One sub-module is natural: t5_rrarb, a 4-way round-robin priority picker. Inputs are a request mask and rr; outputs are a grant index and a valid flag. It is purely combinational.
- PC file, state bits and output registers stay in t5_hart.

Test Plan:
- Reset, then hold ena=1 with no writeback → fvld=1 for exactly one cycle with fadr=RST_VEC>>2 and fhart=0; fvld=0 thereafter.
- Each cycle, write back hart 0 with wb_pc=fadr+1, starting from reset → fhart=0 every cycle and fadr increments 0,1,2,3.
- Start harts 1,2,3 with start_pc 0x100, 0x200, 0x300 (word addresses), all writeback immediate → issue order 0,1,2,3 repeats with the correct per-hart addresses.
- halt_stb on hart 2 and wb_stb on hart 2 in the same cycle → pcf[2]=wb_pc, run=4'b1011, and hart 2 is never issued; a later start_stb on hart 2 with 0x40 → the next issue of hart 2 has fadr=0x40.
- Drop ena for 3 cycles mid-stream while wb_stb is asserted → outputs are frozen and the writeback is not applied until ena returns.
- Assert rst while all harts are pending → next-cycle state is run=0001, pend=0, fvld=0, fadr=0, fhart=0; the following cycle issues hart 0 at RST_VEC.

Source files
------------

// File: rtl/t5_pkg.sv
// ------------------------------------------------------------------
// t5_pkg: shared constants and types for the four-hart scheduler.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package t5_pkg;
   localparam int NHART     = 4;
   localparam int HART_W    = 2;
   localparam int WORD_XLEN = 32;

   typedef logic [HART_W-1:0]    hart_t;
   typedef logic [WORD_XLEN-1:2] wadr_t;
endpackage

`default_nettype wire

// File: rtl/t5_rrarb.sv
// ------------------------------------------------------------------
// t5_rrarb: combinational 4-way round-robin picker, priority from rr.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module t5_rrarb
   import t5_pkg::*;
(
   input  logic [NHART-1:0] req,
   input  hart_t            rr,
   output hart_t            gnt,
   output logic             vld
);

   hart_t idx;

   // Walk from the farthest candidate back to rr so the nearest requester wins.
   always_comb begin
      gnt = rr;
      vld = 1'b0;
      idx = '0;
      for (int k = NHART - 1; k >= 0; k--) begin
         idx = rr + hart_t'(k);
         if (req[idx]) begin
            gnt = idx;
            vld = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/t5_hart.sv
// ------------------------------------------------------------------
// t5_hart: per-hart PC file, round-robin issue and fetch address output.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module t5_hart
   import t5_pkg::*;
#(
   parameter int               XLEN    = 32,
   parameter logic [XLEN-1:0]  RST_VEC = XLEN'(32'h0000_0000)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              wb_stb,
   input  hart_t             wb_hart,
   input  logic [XLEN-1:2]   wb_pc,
   input  logic              start_stb,
   input  hart_t             start_hart,
   input  logic [XLEN-1:2]   start_pc,
   input  logic              halt_stb,
   input  hart_t             halt_hart,
   output logic [XLEN-1:2]   fadr,
   output hart_t             fhart,
   output logic              fvld,
   output logic [NHART-1:0]  run
);

   logic [XLEN-1:2]  pcf_q [NHART];
   logic [XLEN-1:2]  pcf_d [NHART];
   logic [NHART-1:0] run_q, run_d, pend_q, pend_d;
   logic [NHART-1:0] wb_mask, halt_mask, elig;
   logic [XLEN-1:2]  fadr_q, fadr_d;
   hart_t            fhart_q, fhart_d, rr_q, rr_d, gnt;
   logic             fvld_q, fvld_d, gnt_vld;

   // A retiring hart is eligible in the same scan; a hart being halted is not.
   always_comb begin
      wb_mask   = '0;
      halt_mask = '0;
      if (wb_stb)   wb_mask[wb_hart]     = 1'b1;
      if (halt_stb) halt_mask[halt_hart] = 1'b1;
      elig = run_q & ~(pend_q & ~wb_mask) & ~halt_mask;
   end

   t5_rrarb u_arb (
      .req (elig),
      .rr  (rr_q),
      .gnt (gnt),
      .vld (gnt_vld)
   );

   always_comb begin
      pcf_d   = pcf_q;
      run_d   = run_q;
      pend_d  = pend_q;
      fadr_d  = fadr_q;
      fhart_d = fhart_q;
      fvld_d  = fvld_q;
      rr_d    = rr_q;
      if (ena) begin
         if (wb_stb) begin
            pcf_d[wb_hart]  = wb_pc;
            pend_d[wb_hart] = 1'b0;
         end
         if (gnt_vld) begin
            fadr_d      = pcf_d[gnt];
            fhart_d     = gnt;
            fvld_d      = 1'b1;
            pend_d[gnt] = 1'b1;
            rr_d        = gnt + 2'd1;
         end else begin
            fvld_d = 1'b0;
         end
         // Start is applied after writeback so start_pc wins on a parked hart.
         if (start_stb && !run_q[start_hart]) begin
            pcf_d[start_hart]  = start_pc;
            pend_d[start_hart] = 1'b0;
            run_d[start_hart]  = 1'b1;
         end
         if (halt_stb) run_d[halt_hart] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcf_q[0] <= RST_VEC[XLEN-1:2];
         for (int h = 1; h < NHART; h++) pcf_q[h] <= '0;
         run_q   <= {{(NHART-1){1'b0}}, 1'b1};
         pend_q  <= '0;
         fadr_q  <= '0;
         fhart_q <= '0;
         fvld_q  <= 1'b0;
         rr_q    <= '0;
      end else begin
         pcf_q   <= pcf_d;
         run_q   <= run_d;
         pend_q  <= pend_d;
         fadr_q  <= fadr_d;
         fhart_q <= fhart_d;
         fvld_q  <= fvld_d;
         rr_q    <= rr_d;
      end
   end

   assign fadr  = fadr_q;
   assign fhart = fhart_q;
   assign fvld  = fvld_q;
   assign run   = run_q;

endmodule

`default_nettype wire

// File: tb/tb_t5_hart.sv
// ------------------------------------------------------------------
// tb_t5_hart: scoreboard bench for t5_hart against a rule-level model.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_t5_hart;
   import t5_pkg::*;

   localparam int          XLEN = 32;
   localparam logic [31:0] RV   = 32'h0000_1007;

   logic            clk = 1'b0;
   logic            rst = 1'b1, ena = 1'b0;
   logic            wb_stb = 1'b0, start_stb = 1'b0, halt_stb = 1'b0;
   hart_t           wb_hart = '0, start_hart = '0, halt_hart = '0;
   logic [XLEN-1:2] wb_pc = '0, start_pc = '0;
   logic [XLEN-1:2] fadr;
   hart_t           fhart;
   logic            fvld;
   logic [3:0]      run;

   t5_hart #(.XLEN(XLEN), .RST_VEC(RV)) dut (
      .clk(clk), .rst(rst), .ena(ena),
      .wb_stb(wb_stb), .wb_hart(wb_hart), .wb_pc(wb_pc),
      .start_stb(start_stb), .start_hart(start_hart), .start_pc(start_pc),
      .halt_stb(halt_stb), .halt_hart(halt_hart),
      .fadr(fadr), .fhart(fhart), .fvld(fvld), .run(run)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       fvld;
      wadr_t      fadr;
      int         fhart;
      logic [3:0] run;
   } exp_t;

   exp_t  expq[$];
   int    checks = 0;
   int    failures = 0;

   wadr_t m_pc[4];
   bit    m_run[4];
   bit    m_pend[4];
   int    m_rr;
   logic  m_fvld;
   wadr_t m_fadr;
   int    m_fhart;
   int    infl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_pc[0] = RV[31:2];
      for (int h = 1; h < 4; h++) m_pc[h] = '0;
      for (int h = 0; h < 4; h++) begin
         m_run[h]  = (h == 0);
         m_pend[h] = 1'b0;
      end
      m_rr = 0; m_fvld = 1'b0; m_fadr = '0; m_fhart = 0;
      infl.delete();
   endtask

   // Rules applied in plain order: retire, pick, start, park.
   task automatic model_step(input bit w, input int wh, input wadr_t wp,
                             input bit s, input int sh, input wadr_t sp,
                             input bit hl, input int hh);
      int pick;
      pick = -1;
      if (w) begin
         m_pc[wh] = wp;
         if (m_pend[wh]) begin
            for (int i = 0; i < infl.size(); i++)
               if (infl[i] == wh) begin infl.delete(i); break; end
         end
         m_pend[wh] = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         int c;
         c = (m_rr + k) % 4;
         if (pick < 0 && m_run[c] && !m_pend[c] && !(hl && hh == c)) pick = c;
      end
      if (pick >= 0) begin
         m_fvld = 1'b1; m_fadr = m_pc[pick]; m_fhart = pick;
         m_pend[pick] = 1'b1; m_rr = (pick + 1) % 4;
         infl.push_back(pick);
      end else begin
         m_fvld = 1'b0;
      end
      if (s && !m_run[sh]) begin
         m_run[sh] = 1'b1; m_pc[sh] = sp; m_pend[sh] = 1'b0;
      end
      if (hl) m_run[hh] = 1'b0;
   endtask

   task automatic step(input bit r, input bit e,
                       input bit w, input int wh, input wadr_t wp,
                       input bit s, input int sh, input wadr_t sp,
                       input bit hl, input int hh);
      exp_t x;
      @(negedge clk);
      rst = r; ena = e;
      wb_stb = w;     wb_hart = hart_t'(wh);    wb_pc = wp;
      start_stb = s;  start_hart = hart_t'(sh); start_pc = sp;
      halt_stb = hl;  halt_hart = hart_t'(hh);
      @(posedge clk);
      if (r) model_reset();
      else if (e) model_step(w, wh, wp, s, sh, sp, hl, hh);
      x.fvld = m_fvld; x.fadr = m_fadr; x.fhart = m_fhart;
      x.run = {m_run[3], m_run[2], m_run[1], m_run[0]};
      expq.push_back(x);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, 0, '0, 0, 0, '0, 0, 0);
   endtask

   // Retire the oldest in-flight instruction each cycle with next PC = fetch PC + 1.
   task automatic auto_wb(input int n, input bit e);
      for (int i = 0; i < n; i++) begin
         if (infl.size() > 0) step(0, e, 1, infl[0], m_pc[infl[0]] + 1'b1, 0, 0, '0, 0, 0);
         else                 step(0, e, 0, 0, '0, 0, 0, '0, 0, 0);
      end
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            x = expq.pop_front();
            chk("fvld",  64'(fvld),  64'(x.fvld));
            chk("fadr",  64'(fadr),  64'(x.fadr));
            chk("fhart", 64'(fhart), 64'(x.fhart));
            chk("run",   64'(run),   64'(x.run));
         end
      end
   end

   initial begin : stim
      model_reset();
      // Reset, then free-run: a single issue of hart 0 at the reset vector.
      step(1, 1, 0, 0, '0, 0, 0, '0, 0, 0);
      step(1, 1, 0, 0, '0, 0, 0, '0, 0, 0);
      idle(4);
      // Hart 0 alone, retiring every cycle: consecutive addresses.
      step(1, 1, 0, 0, '0, 0, 0, '0, 0, 0);
      auto_wb(6, 1);
      // Start harts 1..3 and rotate through all four.
      step(1, 1, 0, 0, '0, 0, 0, '0, 0, 0);
      step(0, 1, 0, 0, '0, 1, 1, 30'h100, 0, 0);
      step(0, 1, 0, 0, '0, 1, 2, 30'h200, 0, 0);
      step(0, 1, 0, 0, '0, 1, 3, 30'h300, 0, 0);
      auto_wb(16, 1);
      // Park hart 2 while it retires, then restart it elsewhere.
      step(0, 1, 1, 2, 30'h2AA, 0, 0, '0, 1, 2);
      auto_wb(8, 1);
      step(0, 1, 0, 0, '0, 1, 2, 30'h40, 0, 0);
      auto_wb(8, 1);
      // Pipeline stall with a writeback held on the inputs.
      auto_wb(3, 0);
      auto_wb(4, 1);
      // Reset with harts in flight, then restart from the vector.
      step(1, 1, 0, 0, '0, 0, 0, '0, 0, 0);
      idle(2);
      // Randomised traffic.
      for (int i = 0; i < 500; i++) begin
         bit r, e, w, s, hl;
         int wh, sh, hh;
         r = ($urandom_range(0, 199) == 0);
         e = ($urandom_range(0, 9) != 0);
         w = 0; wh = 0; s = 0; sh = 0; hl = 0; hh = 0;
         if (infl.size() > 0 && $urandom_range(0, 9) < 7) begin
            w = 1; wh = infl[$urandom_range(0, infl.size() - 1)];
         end else if ($urandom_range(0, 19) == 0) begin
            w = 1; wh = $urandom_range(0, 3);
         end
         if ($urandom_range(0, 6) == 0) begin s = 1; sh = $urandom_range(0, 3); end
         if ($urandom_range(0, 19) == 0) begin hl = 1; hh = $urandom_range(0, 3); end
         step(r, e, w, wh, wadr_t'($urandom), s, sh, wadr_t'($urandom), hl, hh);
      end
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 64'(expq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
